// File: rtl/pulse_timer_us.sv
// Debounced pulse-train timer: timestamps filtered detect edges against the
// free-running microsecond count and reports pulse width, period and loss of signal.
module pulse_timer_us #(
  parameter int unsigned MAX_COUNT   = 1_999_999,
  parameter int unsigned COUNT_W     = 21,
  parameter int unsigned DEBOUNCE_US = 100,
  parameter int unsigned TIMEOUT_US  = 1_500_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COUNT_W-1:0] us_count_i,
  input  logic               detect_i,
  output logic [COUNT_W-1:0] width_o,
  output logic [COUNT_W-1:0] period_o,
  output logic               meas_valid_o,
  output logic               timeout_o,
  output logic               active_o
);

  localparam int unsigned DEB_W = (DEBOUNCE_US < 2) ? 1 : $clog2(DEBOUNCE_US);
  localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEBOUNCE_US - 1);
  localparam logic [COUNT_W-1:0] MODULUS    = COUNT_W'(MAX_COUNT + 1);
  localparam logic [COUNT_W-1:0] TO_LIMIT   = COUNT_W'(TIMEOUT_US);

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_HIGH_FIRST = 2'd1;
  localparam logic [1:0] ST_HIGH       = 2'd2;
  localparam logic [1:0] ST_LOW        = 2'd3;

  // Modular difference; adding the modulus in COUNT_W bits stays exact because
  // the true result never exceeds MAX_COUNT.
  function automatic logic [COUNT_W-1:0] elapsed(input logic [COUNT_W-1:0] now,
                                                 input logic [COUNT_W-1:0] t0);
    if (now >= t0) return now - t0;
    return now - t0 + MODULUS;
  endfunction

  logic [1:0]         sync_q, sync_d;
  logic [COUNT_W-1:0] prev_count_q, prev_count_d;
  logic               filt_q, filt_d;
  logic [DEB_W-1:0]   deb_cnt_q, deb_cnt_d;
  logic [1:0]         state_q, state_d;
  logic [COUNT_W-1:0] rise_t_q, rise_t_d;
  logic [COUNT_W-1:0] width_r_q, width_r_d;
  logic [COUNT_W-1:0] width_q, width_d;
  logic [COUNT_W-1:0] period_q, period_d;
  logic               meas_valid_q, meas_valid_d;
  logic               timeout_q, timeout_d;

  logic               us_tick, rise_ev, fall_ev;
  logic [COUNT_W-1:0] el;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves a value unassigned (no latch).
    sync_d       = {sync_q[0], detect_i};
    prev_count_d = us_count_i;
    us_tick      = (us_count_i != prev_count_q);
    filt_d       = filt_q;
    deb_cnt_d    = deb_cnt_q;
    rise_ev      = 1'b0;
    fall_ev      = 1'b0;
    if (sync_q[1] == filt_q) begin
      deb_cnt_d = '0;
    end else if (us_tick) begin
      if (deb_cnt_q == DEB_LAST) begin
        filt_d    = ~filt_q;
        deb_cnt_d = '0;
        rise_ev   = ~filt_q;
        fall_ev   = filt_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    el           = elapsed(us_count_i, rise_t_q);
    state_d      = state_q;
    rise_t_d     = rise_t_q;
    width_r_d    = width_r_q;
    width_d      = width_q;
    period_d     = period_q;
    meas_valid_d = 1'b0;
    timeout_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rise_ev) begin
          rise_t_d = us_count_i;
          state_d  = ST_HIGH_FIRST;
        end
      end
      ST_HIGH_FIRST, ST_HIGH: begin
        if (fall_ev) begin
          width_r_d = el;
          state_d   = ST_LOW;
        end else if (el >= TO_LIMIT && !rise_ev) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end
      end
      ST_LOW: begin
        if (rise_ev) begin
          width_d      = width_r_q;
          period_d     = el;
          meas_valid_d = 1'b1;
          rise_t_d     = us_count_i;
          state_d      = ST_HIGH;
        end else if (el >= TO_LIMIT && !fall_ev) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (rst) begin
      sync_q       <= '0;
      prev_count_q <= '0;
      filt_q       <= 1'b0;
      deb_cnt_q    <= '0;
      state_q      <= ST_IDLE;
      rise_t_q     <= '0;
      width_r_q    <= '0;
      width_q      <= '0;
      period_q     <= '0;
      meas_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      prev_count_q <= prev_count_d;
      filt_q       <= filt_d;
      deb_cnt_q    <= deb_cnt_d;
      state_q      <= state_d;
      rise_t_q     <= rise_t_d;
      width_r_q    <= width_r_d;
      width_q      <= width_d;
      period_q     <= period_d;
      meas_valid_q <= meas_valid_d;
      timeout_q    <= timeout_d;
    end
  end

  assign width_o      = width_q;
  assign period_o     = period_q;
  assign meas_valid_o = meas_valid_q;
  assign timeout_o    = timeout_q;
  assign active_o     = (state_q != ST_IDLE);

endmodule
